// File: rtl/ufi_pkg.sv
// Shared arbiter types: FSM states, one-hot master IDs and the default burst cap.
package ufi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } ufiState_e;

    localparam logic [2:0] VTB = 3'b001;
    localparam logic [2:0] ATB = 3'b010;
    localparam logic [2:0] MCS = 3'b100;

    localparam int BURST_MAX_DEFAULT = 64;

endpackage

// File: rtl/ufi_rr_picker.sv
// Two-way Atb/Mcs round-robin picker; the caller owns the turn pointer.
// Latency: combinational. Backpressure: none, grants are only sampled in IDLE.
// A lone requester always wins; on contention the pointer decides.
module ufi_rr_picker (
    input  logic iReqAtb,
    input  logic iReqMcs,
    input  logic iPreferMcs,
    output logic oGntAtb,
    output logic oGntMcs
);

    assign oGntAtb = iReqAtb & (~iPreferMcs | ~iReqMcs);
    assign oGntMcs = iReqMcs & ( iPreferMcs | ~iReqAtb);

endmodule

// File: rtl/ufi_master_arbiter.sv
// Three-master UFI arbiter in front of one RAM slave: Vtb fixed priority, Atb/Mcs round-robin.
// Latency: request-to-grant 1 cycle; strobes and read returns pass combinationally.
// Backpressure: iSUfiRdy gates slave strobes and master Rdy; bursts end with a 1-cycle GAP.
module ufi_master_arbiter
    import ufi_pkg::*;
#(
    parameter int pUfiBusWidth = 12,
    parameter int pBusAdrsBit  = 32,
    parameter int pUfiIdNumber = 3,
    parameter int pBurstMax    = BURST_MAX_DEFAULT
) (
    input  logic                    iUfiClk,
    input  logic                    iUfiRst,
    input  logic                    iMUfiVdVtb,
    input  logic                    iMUfiVdAtb,
    input  logic                    iMUfiVdMcs,
    input  logic [pBusAdrsBit-1:0]  iMUfiAdrsVtb,
    input  logic [pBusAdrsBit-1:0]  iMUfiAdrsAtb,
    input  logic [pBusAdrsBit-1:0]  iMUfiAdrsMcs,
    input  logic                    iMUfiWEdVtb,
    input  logic                    iMUfiWEdAtb,
    input  logic                    iMUfiWEdMcs,
    input  logic                    iMUfiREdVtb,
    input  logic                    iMUfiREdAtb,
    input  logic                    iMUfiREdMcs,
    input  logic [pUfiBusWidth-1:0] iMUfiWdVtb,
    input  logic [pUfiBusWidth-1:0] iMUfiWdMcs,
    input  logic                    iMUfiCmdVtb,
    input  logic                    iMUfiCmdMcs,
    output logic                    oMUfiRdyVtb,
    output logic                    oMUfiRdyAtb,
    output logic                    oMUfiRdyMcs,
    output logic                    oMUfiEddVtb,
    output logic                    oMUfiEddAtb,
    output logic                    oMUfiEddMcs,
    output logic [pUfiBusWidth-1:0] oMUfiRd,
    output logic [pUfiBusWidth-1:0] oSUfiWd,
    output logic [pBusAdrsBit-1:0]  oSUfiAdrs,
    output logic                    oSUfiWEd,
    output logic                    oSUfiREd,
    output logic                    oSUfiCmd,
    output logic [pUfiIdNumber-1:0] oSUfiIdO,
    input  logic [pUfiBusWidth-1:0] iSUfiRd,
    input  logic                    iSUfiREd,
    input  logic [pUfiIdNumber-1:0] iSUfiIdI,
    input  logic                    iSUfiRdy
);

    localparam int CntW = $clog2(pBurstMax + 1);

    typedef struct packed {
        logic [pBusAdrsBit-1:0]  adrs;
        logic [pUfiBusWidth-1:0] wd;
        logic                    wEd;
        logic                    rEd;
        logic                    cmd;
    } ufiReq_t;

    ufiState_e               state, stateNext;
    logic [pUfiIdNumber-1:0] grant, grantNext;
    logic [CntW-1:0]         burstCnt, burstCntNext;
    logic                    rrMcs, rrMcsNext;

    ufiReq_t reqVtb, reqAtb, reqMcs, reqSel;
    logic    vdSel, accept, anyVd, pickAtb, pickMcs, idOneHot;

    // Atb is a read-only master: no write data, command pinned to read.
    assign reqVtb = '{adrs: iMUfiAdrsVtb, wd: iMUfiWdVtb, wEd: iMUfiWEdVtb,
                      rEd: iMUfiREdVtb, cmd: iMUfiCmdVtb};
    assign reqAtb = '{adrs: iMUfiAdrsAtb, wd: '0, wEd: iMUfiWEdAtb,
                      rEd: iMUfiREdAtb, cmd: 1'b1};
    assign reqMcs = '{adrs: iMUfiAdrsMcs, wd: iMUfiWdMcs, wEd: iMUfiWEdMcs,
                      rEd: iMUfiREdMcs, cmd: iMUfiCmdMcs};

    assign anyVd = iMUfiVdVtb | iMUfiVdAtb | iMUfiVdMcs;

    ufi_rr_picker uRrPicker (
        .iReqAtb    (iMUfiVdAtb),
        .iReqMcs    (iMUfiVdMcs),
        .iPreferMcs (rrMcs),
        .oGntAtb    (pickAtb),
        .oGntMcs    (pickMcs)
    );

    always_comb begin
        reqSel = '0;
        vdSel  = 1'b0;
        unique case (grant)
            pUfiIdNumber'(VTB): begin reqSel = reqVtb; vdSel = iMUfiVdVtb; end
            pUfiIdNumber'(ATB): begin reqSel = reqAtb; vdSel = iMUfiVdAtb; end
            pUfiIdNumber'(MCS): begin reqSel = reqMcs; vdSel = iMUfiVdMcs; end
            default: ;
        endcase
    end

    assign accept = (reqSel.wEd | reqSel.rEd) & iSUfiRdy;

    always_comb begin
        stateNext    = state;
        grantNext    = grant;
        burstCntNext = burstCnt;
        rrMcsNext    = rrMcs;
        unique case (state)
            IDLE: begin
                burstCntNext = '0;
                if (anyVd) begin
                    stateNext = XFER;
                    if (iMUfiVdVtb) begin
                        grantNext = pUfiIdNumber'(VTB);
                    end else if (pickAtb) begin
                        grantNext = pUfiIdNumber'(ATB);
                        rrMcsNext = 1'b1;
                    end else if (pickMcs) begin
                        grantNext = pUfiIdNumber'(MCS);
                        rrMcsNext = 1'b0;
                    end
                end
            end
            XFER: begin
                if (accept) begin
                    burstCntNext = burstCnt + CntW'(1);
                end
                // The strobe in the exit cycle has already been forwarded above.
                if (!vdSel || burstCntNext == CntW'(pBurstMax)) begin
                    stateNext    = GAP;
                    grantNext    = '0;
                    burstCntNext = '0;
                end
            end
            GAP: begin
                stateNext = IDLE;
                grantNext = '0;
            end
            default: begin
                stateNext = IDLE;
                grantNext = '0;
            end
        endcase
    end

    always_ff @(posedge iUfiClk) begin
        if (!iUfiRst) begin
            state    <= IDLE;
            grant    <= '0;
            burstCnt <= '0;
            rrMcs    <= 1'b0;
        end else begin
            state    <= stateNext;
            grant    <= grantNext;
            burstCnt <= burstCntNext;
            rrMcs    <= rrMcsNext;
        end
    end

    // Gate by reset so a grant left over from before the reset edge never leaks out.
    assign oMUfiRdyVtb = grant[0] & iSUfiRdy & iUfiRst;
    assign oMUfiRdyAtb = grant[1] & iSUfiRdy & iUfiRst;
    assign oMUfiRdyMcs = grant[2] & iSUfiRdy & iUfiRst;

    assign oSUfiWEd  = reqSel.wEd & iSUfiRdy & iUfiRst;
    assign oSUfiREd  = reqSel.rEd & iSUfiRdy & iUfiRst;
    assign oSUfiCmd  = reqSel.cmd & iUfiRst;
    assign oSUfiWd   = iUfiRst ? reqSel.wd   : '0;
    assign oSUfiAdrs = iUfiRst ? reqSel.adrs : '0;
    assign oSUfiIdO  = iUfiRst ? grant       : '0;

    // Read returns follow their tag, not the current grant.
    assign idOneHot = (iSUfiIdI != '0) &&
                      ((iSUfiIdI & (iSUfiIdI - pUfiIdNumber'(1))) == '0);
    assign oMUfiEddVtb = iSUfiREd & idOneHot & iSUfiIdI[0];
    assign oMUfiEddAtb = iSUfiREd & idOneHot & iSUfiIdI[1];
    assign oMUfiEddMcs = iSUfiREd & idOneHot & iSUfiIdI[2];
    assign oMUfiRd     = iSUfiRd;

endmodule

// File: tb/tb_ufi_master_arbiter.sv
// Scoreboard bench for ufi_master_arbiter: expected slave transactions queued as masters strobe.
module tb_ufi_master_arbiter;
    import ufi_pkg::*;

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] adrs;
        logic [11:0] wd;
        logic        wEd;
        logic        rEd;
        logic        cmd;
    } xact_t;

    logic iUfiClk = 1'b0;
    always #5 iUfiClk = ~iUfiClk;

    logic        iUfiRst;
    logic        iMUfiVdVtb, iMUfiVdAtb, iMUfiVdMcs;
    logic [31:0] iMUfiAdrsVtb, iMUfiAdrsAtb, iMUfiAdrsMcs;
    logic        iMUfiWEdVtb, iMUfiWEdAtb, iMUfiWEdMcs;
    logic        iMUfiREdVtb, iMUfiREdAtb, iMUfiREdMcs;
    logic [11:0] iMUfiWdVtb, iMUfiWdMcs;
    logic        iMUfiCmdVtb, iMUfiCmdMcs;
    logic        oMUfiRdyVtb, oMUfiRdyAtb, oMUfiRdyMcs;
    logic        oMUfiEddVtb, oMUfiEddAtb, oMUfiEddMcs;
    logic [11:0] oMUfiRd, oSUfiWd;
    logic [31:0] oSUfiAdrs;
    logic        oSUfiWEd, oSUfiREd, oSUfiCmd;
    logic [2:0]  oSUfiIdO;
    logic [11:0] iSUfiRd;
    logic        iSUfiREd;
    logic [2:0]  iSUfiIdI;
    logic        iSUfiRdy;

    int    checks = 0;
    int    failures = 0;
    int    fwdCount = 0;
    logic  tbRrMcs = 1'b0;
    xact_t expQ[$];
    xact_t monAct, monExp;

    logic [2:0] retIds [7] = '{3'b010, 3'b011, 3'b100, 3'b001, 3'b000, 3'b111, 3'b010};
    logic       retReds[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    ufi_master_arbiter #(
        .pUfiBusWidth(12), .pBusAdrsBit(32), .pUfiIdNumber(3), .pBurstMax(64)
    ) dut (
        .iUfiClk(iUfiClk), .iUfiRst(iUfiRst),
        .iMUfiVdVtb(iMUfiVdVtb), .iMUfiVdAtb(iMUfiVdAtb), .iMUfiVdMcs(iMUfiVdMcs),
        .iMUfiAdrsVtb(iMUfiAdrsVtb), .iMUfiAdrsAtb(iMUfiAdrsAtb), .iMUfiAdrsMcs(iMUfiAdrsMcs),
        .iMUfiWEdVtb(iMUfiWEdVtb), .iMUfiWEdAtb(iMUfiWEdAtb), .iMUfiWEdMcs(iMUfiWEdMcs),
        .iMUfiREdVtb(iMUfiREdVtb), .iMUfiREdAtb(iMUfiREdAtb), .iMUfiREdMcs(iMUfiREdMcs),
        .iMUfiWdVtb(iMUfiWdVtb), .iMUfiWdMcs(iMUfiWdMcs),
        .iMUfiCmdVtb(iMUfiCmdVtb), .iMUfiCmdMcs(iMUfiCmdMcs),
        .oMUfiRdyVtb(oMUfiRdyVtb), .oMUfiRdyAtb(oMUfiRdyAtb), .oMUfiRdyMcs(oMUfiRdyMcs),
        .oMUfiEddVtb(oMUfiEddVtb), .oMUfiEddAtb(oMUfiEddAtb), .oMUfiEddMcs(oMUfiEddMcs),
        .oMUfiRd(oMUfiRd), .oSUfiWd(oSUfiWd), .oSUfiAdrs(oSUfiAdrs),
        .oSUfiWEd(oSUfiWEd), .oSUfiREd(oSUfiREd), .oSUfiCmd(oSUfiCmd), .oSUfiIdO(oSUfiIdO),
        .iSUfiRd(iSUfiRd), .iSUfiREd(iSUfiREd), .iSUfiIdI(iSUfiIdI), .iSUfiRdy(iSUfiRdy)
    );

    // Every strobe reaching the slave must match the oldest queued expectation.
    always @(negedge iUfiClk) begin
        if (oSUfiWEd || oSUfiREd) begin
            monAct = '{id: oSUfiIdO, adrs: oSUfiAdrs, wd: oSUfiWd,
                       wEd: oSUfiWEd, rEd: oSUfiREd, cmd: oSUfiCmd};
            fwdCount++;
            checks++;
            if (expQ.size() == 0) begin
                failures++;
                $display("FAIL slave_xact unexpected actual=%h expected=none", monAct);
            end else begin
                monExp = expQ.pop_front();
                if (monAct !== monExp) begin
                    failures++;
                    $display("FAIL slave_xact actual=%h expected=%h", monAct, monExp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge iUfiClk);
        #1;
    endtask

    task automatic idleIn();
        iMUfiVdVtb = 0; iMUfiVdAtb = 0; iMUfiVdMcs = 0;
        iMUfiWEdVtb = 0; iMUfiWEdAtb = 0; iMUfiWEdMcs = 0;
        iMUfiREdVtb = 0; iMUfiREdAtb = 0; iMUfiREdMcs = 0;
        iMUfiAdrsVtb = 0; iMUfiAdrsAtb = 0; iMUfiAdrsMcs = 0;
        iMUfiWdVtb = 0; iMUfiWdMcs = 0; iMUfiCmdVtb = 0; iMUfiCmdMcs = 0;
        iSUfiRd = 0; iSUfiREd = 0; iSUfiIdI = 0;
    endtask

    task automatic test_reset();
        iUfiRst = 0; iSUfiRdy = 1;
        iMUfiVdVtb = 1; iMUfiVdAtb = 1; iMUfiVdMcs = 1;
        iMUfiWEdVtb = 1; iMUfiREdAtb = 1; iMUfiWEdMcs = 1;
        iMUfiAdrsVtb = 32'hAAAA_0001; iMUfiWdVtb = 12'hABC; iMUfiCmdVtb = 1;
        tick();
        @(negedge iUfiClk);
        checks += 5;
        if ({oMUfiRdyVtb, oMUfiRdyAtb, oMUfiRdyMcs} !== 3'b000) begin
            failures++; $display("FAIL reset_rdy actual=%b expected=000", {oMUfiRdyVtb, oMUfiRdyAtb, oMUfiRdyMcs});
        end
        if ({oSUfiWEd, oSUfiREd, oSUfiCmd} !== 3'b000) begin
            failures++; $display("FAIL reset_strobes actual=%b expected=000", {oSUfiWEd, oSUfiREd, oSUfiCmd});
        end
        if ({oSUfiWd, oSUfiAdrs, oSUfiIdO} !== '0) begin
            failures++; $display("FAIL reset_bus actual=%h/%h/%b expected=0", oSUfiWd, oSUfiAdrs, oSUfiIdO);
        end
        if (dut.state !== IDLE || dut.grant !== 3'b000) begin
            failures++; $display("FAIL reset_fsm actual=%0d/%b expected=IDLE/000", dut.state, dut.grant);
        end
        if (dut.burstCnt !== 0 || dut.rrMcs !== 1'b0) begin
            failures++; $display("FAIL reset_cnt_ptr actual=%0d/%b expected=0/0", dut.burstCnt, dut.rrMcs);
        end
        tick();
        idleIn(); iUfiRst = 1;
        tick(); tick();
        tbRrMcs = 0;
    endtask

    task automatic test_atb_burst();
        iMUfiVdAtb = 1;
        @(negedge iUfiClk);
        checks++;
        if (oMUfiRdyAtb !== 1'b0 || oSUfiIdO !== 3'b000) begin
            failures++; $display("FAIL atb_pregrant actual=%b/%b expected=0/000", oMUfiRdyAtb, oSUfiIdO);
        end
        tbRrMcs = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            iMUfiREdAtb = 1; iMUfiAdrsAtb = 32'h100 + k;
            iMUfiVdAtb = (k != 9);
            expQ.push_back('{id: ATB, adrs: 32'h100 + k, wd: 12'h0, wEd: 0, rEd: 1, cmd: 1});
            @(negedge iUfiClk);
            if (k == 0) begin
                checks++;
                if (oMUfiRdyAtb !== 1'b1 || oSUfiIdO !== ATB) begin
                    failures++; $display("FAIL atb_grant_latency actual=%b/%b expected=1/010", oMUfiRdyAtb, oSUfiIdO);
                end
            end
        end
        tick(); idleIn();
        @(negedge iUfiClk);
        checks++;
        if (dut.state !== GAP || oSUfiIdO !== 3'b000 || oMUfiRdyAtb !== 1'b0) begin
            failures++; $display("FAIL atb_gap actual=%0d/%b expected=GAP/000", dut.state, oSUfiIdO);
        end
        tick();
        @(negedge iUfiClk);
        checks += 2;
        if (dut.state !== IDLE) begin
            failures++; $display("FAIL atb_gap_len actual=%0d expected=IDLE", dut.state);
        end
        if (expQ.size() != 0) begin
            failures++; $display("FAIL atb_drain actual=%0d expected=0", expQ.size());
        end
        tick();
    endtask

    task automatic test_burst_cap();
        int base = fwdCount;
        iMUfiVdVtb = 1; iMUfiVdAtb = 1; iMUfiVdMcs = 1;
        iMUfiWEdVtb = 1; iMUfiCmdVtb = 0; iMUfiWdVtb = 0; iMUfiAdrsVtb = 32'h500;
        iMUfiREdAtb = 1; iMUfiWEdMcs = 1; iMUfiCmdMcs = 0;
        for (int c = 1; c <= 64; c++) begin
            tick();
            iMUfiWdVtb = 12'(c); iMUfiAdrsVtb = 32'h500 + c;
            expQ.push_back('{id: VTB, adrs: 32'h500 + c, wd: 12'(c), wEd: 1, rEd: 0, cmd: 0});
            if (c == 1) begin
                @(negedge iUfiClk);
                checks++;
                if (oSUfiIdO !== VTB) begin
                    failures++; $display("FAIL cap_vtb_first actual=%b expected=001", oSUfiIdO);
                end
            end
        end
        tick(); iMUfiWdVtb = 12'd65;
        @(negedge iUfiClk);
        checks++;
        if (dut.state !== GAP || oSUfiIdO !== 3'b000 || oMUfiRdyVtb !== 1'b0) begin
            failures++; $display("FAIL cap_gap actual=%0d/%b expected=GAP/000", dut.state, oSUfiIdO);
        end
        tick();
        @(negedge iUfiClk);
        checks++;
        if (dut.state !== IDLE || oSUfiIdO !== 3'b000) begin
            failures++; $display("FAIL cap_idle actual=%0d/%b expected=IDLE/000", dut.state, oSUfiIdO);
        end
        tick(); iMUfiWdVtb = 12'd67; iMUfiAdrsVtb = 32'h567;
        expQ.push_back('{id: VTB, adrs: 32'h567, wd: 12'd67, wEd: 1, rEd: 0, cmd: 0});
        @(negedge iUfiClk);
        checks++;
        if (oSUfiIdO !== VTB) begin
            failures++; $display("FAIL cap_vtb_regain actual=%b expected=001", oSUfiIdO);
        end
        tick(); idleIn();
        tick(); tick();
        checks += 2;
        if (fwdCount - base != 65) begin
            failures++; $display("FAIL cap_strobe_count actual=%0d expected=65", fwdCount - base);
        end
        if (expQ.size() != 0) begin
            failures++; $display("FAIL cap_drain actual=%0d expected=0", expQ.size());
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] expG;
        iMUfiVdAtb = 1; iMUfiVdMcs = 1;
        tick();
        for (int r = 0; r < 4; r++) begin
            expG = tbRrMcs ? MCS : ATB;
            tbRrMcs = !tbRrMcs;
            iMUfiREdAtb = 1; iMUfiAdrsAtb = 32'h300 + r;
            iMUfiREdMcs = 1; iMUfiAdrsMcs = 32'h400 + r; iMUfiWdMcs = 12'h50 + 12'(r); iMUfiCmdMcs = 1;
            if (expG == ATB) begin
                iMUfiVdAtb = 0;
                expQ.push_back('{id: ATB, adrs: 32'h300 + r, wd: 12'h0, wEd: 0, rEd: 1, cmd: 1});
            end else begin
                iMUfiVdMcs = 0;
                expQ.push_back('{id: MCS, adrs: 32'h400 + r, wd: 12'h50 + 12'(r), wEd: 0, rEd: 1, cmd: 1});
            end
            @(negedge iUfiClk);
            checks++;
            if (oSUfiIdO !== expG) begin
                failures++; $display("FAIL rr_grant round=%0d actual=%b expected=%b", r, oSUfiIdO, expG);
            end
            tick();
            iMUfiREdAtb = 0; iMUfiREdMcs = 0;
            iMUfiVdAtb = (r != 3); iMUfiVdMcs = (r != 3);
            @(negedge iUfiClk);
            checks++;
            if (oSUfiIdO !== 3'b000) begin
                failures++; $display("FAIL rr_gap round=%0d actual=%b expected=000", r, oSUfiIdO);
            end
            tick();
            tick();
        end
        idleIn();
        checks++;
        if (expQ.size() != 0) begin
            failures++; $display("FAIL rr_drain actual=%0d expected=0", expQ.size());
        end
    endtask

    task automatic test_rdy_toggle();
        int   base = fwdCount;
        int   n = 0;
        logic rdy;
        iMUfiVdVtb = 1; iSUfiRdy = 1;
        for (int cyc = 0; cyc < 200 && n < 20; cyc++) begin
            tick();
            rdy = ((cyc % 3) != 1);
            iSUfiRdy = rdy;
            iMUfiWEdVtb = 1; iMUfiCmdVtb = 0;
            iMUfiWdVtb = 12'h700 + 12'(n); iMUfiAdrsVtb = 32'h600 + n;
            if (rdy) begin
                expQ.push_back('{id: VTB, adrs: 32'h600 + n, wd: 12'h700 + 12'(n), wEd: 1, rEd: 0, cmd: 0});
                n++;
            end
            @(negedge iUfiClk);
            checks++;
            if (oMUfiRdyVtb !== rdy) begin
                failures++; $display("FAIL rdy_follow cyc=%0d actual=%b expected=%b", cyc, oMUfiRdyVtb, rdy);
            end
        end
        checks++;
        if (n != 20) begin
            failures++; $display("FAIL rdy_timeout actual=%0d expected=20", n);
        end
        tick(); idleIn(); iSUfiRdy = 1;
        @(negedge iUfiClk);
        checks++;
        if (dut.burstCnt !== 20) begin
            failures++; $display("FAIL rdy_burst_cnt actual=%0d expected=20", dut.burstCnt);
        end
        tick(); tick();
        checks += 2;
        if (fwdCount - base != 20) begin
            failures++; $display("FAIL rdy_strobe_count actual=%0d expected=20", fwdCount - base);
        end
        if (expQ.size() != 0) begin
            failures++; $display("FAIL rdy_drain actual=%0d expected=0", expQ.size());
        end
    endtask

    task automatic test_read_return();
        logic [2:0] expEdd;
        iMUfiVdMcs = 1;
        tick();
        tbRrMcs = 0;
        @(negedge iUfiClk);
        checks++;
        if (oSUfiIdO !== MCS) begin
            failures++; $display("FAIL ret_mcs_grant actual=%b expected=100", oSUfiIdO);
        end
        for (int i = 0; i < 7; i++) begin
            tick();
            iSUfiREd = retReds[i]; iSUfiIdI = retIds[i]; iSUfiRd = 12'h9A0 + 12'(i);
            expEdd = (retReds[i] && $countones(retIds[i]) == 1) ? retIds[i] : 3'b000;
            @(negedge iUfiClk);
            checks += 2;
            if ({oMUfiEddMcs, oMUfiEddAtb, oMUfiEddVtb} !== expEdd) begin
                failures++; $display("FAIL ret_edd id=%b actual=%b expected=%b", retIds[i],
                                     {oMUfiEddMcs, oMUfiEddAtb, oMUfiEddVtb}, expEdd);
            end
            if (oMUfiRd !== 12'h9A0 + 12'(i)) begin
                failures++; $display("FAIL ret_rd actual=%h expected=%h", oMUfiRd, 12'h9A0 + 12'(i));
            end
        end
        tick(); idleIn();
        tick(); tick();
    endtask

    task automatic test_reset_mid_burst();
        iMUfiVdVtb = 1;
        tick();
        iMUfiWEdVtb = 1; iMUfiCmdVtb = 0; iMUfiWdVtb = 12'h111; iMUfiAdrsVtb = 32'h800;
        expQ.push_back('{id: VTB, adrs: 32'h800, wd: 12'h111, wEd: 1, rEd: 0, cmd: 0});
        @(negedge iUfiClk);
        checks++;
        if (oMUfiRdyVtb !== 1'b1) begin
            failures++; $display("FAIL rstmid_pre actual=%b expected=1", oMUfiRdyVtb);
        end
        tick();
        iUfiRst = 0; iMUfiWdVtb = 12'h112;
        @(negedge iUfiClk);
        checks++;
        if ({oMUfiRdyVtb, oMUfiRdyAtb, oMUfiRdyMcs, oSUfiWEd, oSUfiREd} !== 5'b0) begin
            failures++; $display("FAIL rstmid_during actual=%b expected=00000",
                                 {oMUfiRdyVtb, oMUfiRdyAtb, oMUfiRdyMcs, oSUfiWEd, oSUfiREd});
        end
        tick();
        iUfiRst = 1; iMUfiWdVtb = 12'h113;
        tbRrMcs = 0;
        @(negedge iUfiClk);
        checks += 2;
        if ({oMUfiRdyVtb, oMUfiRdyAtb, oMUfiRdyMcs, oSUfiWEd, oSUfiREd} !== 5'b0) begin
            failures++; $display("FAIL rstmid_after actual=%b expected=00000",
                                 {oMUfiRdyVtb, oMUfiRdyAtb, oMUfiRdyMcs, oSUfiWEd, oSUfiREd});
        end
        if (dut.state !== IDLE) begin
            failures++; $display("FAIL rstmid_state actual=%0d expected=IDLE", dut.state);
        end
        tick(); idleIn();
        tick(); tick();
        checks++;
        if (expQ.size() != 0) begin
            failures++; $display("FAIL rstmid_drain actual=%0d expected=0", expQ.size());
        end
    endtask

    initial begin
        idleIn();
        iUfiRst = 0;
        iSUfiRdy = 1;
        test_reset();
        test_atb_burst();
        test_burst_cap();
        test_round_robin();
        test_rdy_toggle();
        test_read_return();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ufi_master_arbiter.md
UFI_MASTER_ARBITER -- requirements
Module: ufi_master_arbiter

Interface
REQ-001 SHALL have parameter pUfiBusWidth, default 12, meaning data width of the UFI bus.
REQ-002 SHALL have parameter pBusAdrsBit, default 32, meaning address width of the UFI bus.
REQ-003 SHALL have parameter pUfiIdNumber, default 3, meaning width of the one-hot master ID.
REQ-004 SHALL have parameter pBurstMax, default 64, meaning the maximum number of accepted strobes per grant.
REQ-005 SHALL have port iUfiClk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port iUfiRst, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have ports iMUfiVd{Vtb,Atb,Mcs}, input, 1 bit each: request/transfer window per master.
REQ-008 SHALL have ports iMUfiAdrs{Vtb,Atb,Mcs}, input, pBusAdrsBit each: per-master address.
REQ-009 SHALL have ports iMUfiWEd{Vtb,Atb,Mcs} and iMUfiREd{Vtb,Atb,Mcs}, input, 1 bit each: write and read strobes.
REQ-010 SHALL have ports iMUfiWdVtb and iMUfiWdMcs, input, pUfiBusWidth each: write data (Atb is read-only).
REQ-011 SHALL have ports iMUfiCmdVtb and iMUfiCmdMcs, input, 1 bit each: 1 = read, 0 = write (Atb is always read).
REQ-012 SHALL have ports oMUfiRdy{Vtb,Atb,Mcs}, output, 1 bit each: per-master ready.
REQ-013 SHALL have ports oMUfiEdd{Vtb,Atb,Mcs}, output, 1 bit each: per-master read-data valid.
REQ-014 SHALL have port oMUfiRd, output, pUfiBusWidth: read data broadcast to all masters.
REQ-015 SHALL have ports oSUfiWd, oSUfiAdrs, oSUfiWEd, oSUfiREd and oSUfiCmd, output: muxed request to the RAM slave.
REQ-016 SHALL have port oSUfiIdO, output, pUfiIdNumber: one-hot ID of the granted master, sent with each strobe.
REQ-017 SHALL have ports iSUfiRd, iSUfiREd, iSUfiIdI and iSUfiRdy, input: slave read data, read valid, returned ID, and ready.

Function
REQ-018 SHALL implement FSM states IDLE, XFER and GAP.
REQ-019 In IDLE, when any Vd is high, SHALL register a grant; XFER follows in the next cycle (1-cycle request-to-grant latency).
REQ-020 SHALL use fixed priority Vtb > {Atb, Mcs}, with round-robin between Atb and Mcs; the pointer toggles after each Atb or Mcs grant.
REQ-021 In XFER, SHALL mux the granted master's Adrs, Wd, WEd, REd and Cmd to the slave; slave strobes are gated by iSUfiRdy.
REQ-022 SHALL drive oMUfiRdyX = grant(X) & iSUfiRdy; non-granted masters see Rdy=0.
REQ-023 SHALL keep a burst counter of ceil(log2(pBurstMax+1)) bits, incremented on each (WEd|REd) & Rdy of the granted master.
REQ-024 SHALL move XFER -> GAP when the granted Vd falls or the counter reaches pBurstMax; the counter clears on entry to GAP.
REQ-025 In GAP, SHALL hold grant=none and all slave strobes at 0 for exactly 1 cycle, then return to IDLE.
REQ-026 A strobe that coincides with Vd falling SHALL still be forwarded; a strobe presented while Rdy=0 SHALL NOT be counted or forwarded.
REQ-027 SHALL route read returns independently of the current grant: oMUfiEddX = iSUfiREd & iSUfiIdI[X], oMUfiRd = iSUfiRd (combinational).
REQ-028 ID encoding SHALL be Vtb=001, Atb=010, Mcs=100; an iSUfiIdI value that is not one-hot SHALL assert no Edd.
REQ-029 A master capped by pBurstMax that keeps Vd high SHALL re-compete in IDLE; Vtb regains the grant if it is still requesting.
REQ-030 SHALL ignore Vd of non-granted masters during XFER; there is no preemption mid-grant.

Reset
REQ-031 When iUfiRst=0 at a clock edge, SHALL set the state to IDLE, the grant to none, the counter to 0 and the round-robin pointer to Atb.
REQ-032 During reset, SHALL hold all oMUfiRdy, oSUfiWEd, oSUfiREd and oSUfiCmd at 0, and oSUfiWd, oSUfiAdrs and oSUfiIdO at 0.
REQ-033 Reset asserted mid-XFER SHALL abort the grant in the same edge; no strobe is forwarded in the following cycle.

Structure
REQ-034 SHALL place the FSM state enum, the one-hot ID constants (VTB/ATB/MCS) and the pBurstMax default in a shared package, ufi_pkg.
REQ-035 SHALL implement the 2-way Atb/Mcs round-robin picker as the single sub-module ufi_rr_picker; muxing and the FSM stay in the top level.

Verification
REQ-036 Only Atb raises Vd with 10 REd at Rdy=1 -> grant in 1 cycle, 10 slave REd with IdO=010, then GAP for 1 cycle.
REQ-037 Vtb, Atb and Mcs raise Vd simultaneously with continuous strobes and pBurstMax=64 -> Vtb is granted first; after 64 strobes, 1 GAP cycle, then Vtb again.
REQ-038 Atb and Mcs request repeatedly with no Vtb -> grants alternate Atb, Mcs, Atb, Mcs.
REQ-039 iSUfiRdy is toggled 0/1 during a Vtb burst of 20 writes -> exactly 20 slave WEd, and the counter reads 20 at release.
REQ-040 Read returns tagged 010 arrive while Mcs is granted -> only oMUfiEddAtb pulses; tag 011 -> no Edd.
REQ-041 iUfiRst=0 for 1 cycle mid-burst -> the next cycle shows all Rdy and strobes at 0 and the state is IDLE.
